// File: rtl/screen_rect_writer_pkg.sv
// -----------------------------------------------------------------------------
// screen_rect_writer_pkg
// Shared constants for the rectangle-fill engine that draws into the 320x240
// monochrome (1 bpp) screen memory.
//   - screen geometry and memory word width
//   - command op encodings (2'b11 is accepted and handled as set)
//   - FSM state encoding
//   - row_offset(): y * WORDS_PER_ROW built from shifts (y*16 + y*4)
// -----------------------------------------------------------------------------
package screen_rect_writer_pkg;

    localparam int H_RES         = 320;
    localparam int V_RES         = 240;
    localparam int WORD_W        = 16;
    localparam int WORDS_PER_ROW = H_RES / WORD_W;   // 20

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // y * 20 without a multiplier: (y << 4) + (y << 2).
    function automatic logic [15:0] row_offset(input logic [7:0] y);
        logic [15:0] y_ext;
        y_ext = {8'd0, y};
        return (y_ext << 4) + (y_ext << 2);
    endfunction

endpackage

// File: rtl/screen_rect_writer_edge_mask_gen.sv
// -----------------------------------------------------------------------------
// edge_mask_gen
// Purely combinational pixel mask for one memory word of a rectangle span.
// Ports:
//   x0_i      [8:0]  left column of the span, inclusive
//   x1_i      [8:0]  right column of the span, inclusive
//   col_i     [4:0]  word column (pixels col*16 .. col*16+15)
//   mask_o    [15:0] bit i set when pixel col*16+i lies inside [x0, x1]
//   is_full_o        all 16 pixels of the word are covered
// Only meaningful for x0/16 <= col <= x1/16, which is all the caller asks for.
// -----------------------------------------------------------------------------
module edge_mask_gen
    import screen_rect_writer_pkg::*;
(
    input  logic [8:0]        x0_i,
    input  logic [8:0]        x1_i,
    input  logic [4:0]        col_i,
    output logic [WORD_W-1:0] mask_o,
    output logic              is_full_o
);

    logic [8:0] col_first;
    logic [8:0] col_last;
    logic [3:0] lo_bit;
    logic [3:0] hi_bit;

    assign col_first = {col_i, 4'h0};
    assign col_last  = {col_i, 4'hF};

    // Clip the span to this word: lo = max(x0, col*16) % 16, hi = min(x1, col*16+15) % 16.
    assign lo_bit = (x0_i > col_first) ? x0_i[3:0] : 4'd0;
    assign hi_bit = (x1_i < col_last)  ? x1_i[3:0] : 4'd15;

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_mask
            assign mask_o[gi] = (4'(gi) >= lo_bit) && (4'(gi) <= hi_bit);
        end
    endgenerate

    assign is_full_o = (lo_bit == 4'd0) && (hi_bit == 4'd15);

endmodule

// File: rtl/screen_rect_writer.sv
// -----------------------------------------------------------------------------
// screen_rect_writer
// Rectangle fill engine (clear / set / invert) on the write port of the screen
// RAM. One command is taken via valid/ready while IDLE, checked, then walked
// row by row (y0..y1) and word column by word column (x0/16..x1/16).
// Partial words and every invert word use a READ/WRITE pair on the same
// address; fully covered words with set or clear are written blind in one cycle.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o command handshake (ready only in IDLE)
//   cmd_x0_i, cmd_y0_i        top-left corner, inclusive
//   cmd_x1_i, cmd_y1_i        bottom-right corner, inclusive
//   cmd_op_i                  00 clear, 01 set, 10 invert, 11 set
//   mem_addr_o/we_o/wdata_o   screen RAM word port
//   mem_rdata_i               RAM read data, one cycle after the address
//   busy_o, done_o, err_o     status; done/err are one-cycle pulses
// -----------------------------------------------------------------------------
module screen_rect_writer
    import screen_rect_writer_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [8:0]        cmd_x0_i,
    input  logic [7:0]        cmd_y0_i,
    input  logic [8:0]        cmd_x1_i,
    input  logic [7:0]        cmd_y1_i,
    input  logic [1:0]        cmd_op_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_e            state_q;
    logic [8:0]        x0_q, x1_q;
    logic [7:0]        y1_q, row_q;
    logic [4:0]        col_q;
    logic [1:0]        op_q;
    logic [WORD_W-1:0] mask_q;
    logic              full_q;
    logic [ADDR_W-1:0] addr_q, row_addr_q;
    logic              err_q;

    // Mask generator always looks one word ahead: the first word of a new
    // command while IDLE, otherwise the word following the current one.
    logic [8:0]        gen_x0, gen_x1;
    logic [4:0]        gen_col;
    logic [1:0]        gen_op;
    logic [WORD_W-1:0] nx_mask;
    logic              nx_full;
    logic              nx_fast;
    logic              last_col;
    logic              last_row;
    logic              cmd_bad;
    logic [1:0]        op_norm;
    logic [ADDR_W-1:0] start_row_addr;

    assign last_col = (col_q == x1_q[8:4]);
    assign last_row = (row_q == y1_q);
    assign op_norm  = (cmd_op_i == 2'b11) ? OP_SET : cmd_op_i;

    assign cmd_bad = (cmd_x0_i > cmd_x1_i) || (cmd_y0_i > cmd_y1_i) ||
                     (cmd_x1_i >= 9'(H_RES)) || (cmd_y1_i >= 8'(V_RES));

    assign start_row_addr = BASE_ADDR + ADDR_W'(row_offset(cmd_y0_i));

    always_comb begin
        gen_x0  = x0_q;
        gen_x1  = x1_q;
        gen_col = last_col ? x0_q[8:4] : col_q + 5'd1;
        gen_op  = op_q;
        if (state_q == ST_IDLE) begin
            gen_x0  = cmd_x0_i;
            gen_x1  = cmd_x1_i;
            gen_col = cmd_x0_i[8:4];
            gen_op  = op_norm;
        end
    end

    edge_mask_gen u_mask (
        .x0_i      (gen_x0),
        .x1_i      (gen_x1),
        .col_i     (gen_col),
        .mask_o    (nx_mask),
        .is_full_o (nx_full)
    );

    // Full words with set/clear need no read; invert always needs the old data.
    assign nx_fast = nx_full && (gen_op != OP_INV);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            op_q       <= OP_CLR;
            mask_q     <= '0;
            full_q     <= 1'b0;
            addr_q     <= '0;
            row_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            x0_q       <= cmd_x0_i;
                            x1_q       <= cmd_x1_i;
                            y1_q       <= cmd_y1_i;
                            row_q      <= cmd_y0_i;
                            col_q      <= cmd_x0_i[8:4];
                            op_q       <= op_norm;
                            mask_q     <= nx_mask;
                            full_q     <= nx_full;
                            row_addr_q <= start_row_addr;
                            addr_q     <= start_row_addr + ADDR_W'(cmd_x0_i[8:4]);
                            state_q    <= nx_fast ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (last_col && last_row) begin
                        state_q <= ST_FIN;
                    end else begin
                        mask_q <= nx_mask;
                        full_q <= nx_full;
                        col_q  <= gen_col;
                        if (last_col) begin
                            row_q      <= row_q + 8'd1;
                            row_addr_q <= row_addr_q + ADDR_W'(WORDS_PER_ROW);
                            addr_q     <= row_addr_q + ADDR_W'(WORDS_PER_ROW) + ADDR_W'(x0_q[8:4]);
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                        state_q <= nx_fast ? ST_WRITE : ST_READ;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Blind full-word writes must not use mem_rdata_i: nothing was read for them.
    always_comb begin
        mem_wdata_o = '0;
        if (state_q == ST_WRITE) begin
            case (op_q)
                OP_CLR:  mem_wdata_o = full_q ? '0 : (mem_rdata_i & ~mask_q);
                OP_INV:  mem_wdata_o = mem_rdata_i ^ mask_q;
                default: mem_wdata_o = full_q ? '1 : (mem_rdata_i | mask_q);
            endcase
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = (state_q == ST_WRITE);
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_FIN);
    assign err_o       = err_q;

endmodule

// File: doc/screen_rect_writer.md
Name: screen_rect_writer

Overview:
Write-side engine for the 320x240 monochrome screen memory that the VGA controller scans out. It accepts rectangle-fill commands (set, clear or invert) through a valid/ready handshake. Each command is converted into read-modify-write or full-word write cycles on the screen RAM write port. It sits between the CPU/command logic and the second port of the screen RAM, so the display can be drawn at runtime instead of loaded from an init file.

Parameters:
H_RES, 320, visible pixels per row
V_RES, 240, visible rows
WORD_W, 16, pixels per memory word (1 bpp)
ADDR_W, 16, screen memory address width
BASE_ADDR, 0, word address of pixel (0,0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; accept on cmd_valid&cmd_ready
cmd_x0  in  9  left column, inclusive
cmd_y0  in  8  top row, inclusive
cmd_x1  in  9  right column, inclusive
cmd_y1  in  8  bottom row, inclusive
cmd_op  in  2  00 clear, 01 set, 10 invert, 11 treated as set
mem_addr  out  ADDR_W  screen RAM word address
mem_we  out  1  write strobe
mem_wdata  out  WORD_W  write data
mem_rdata  in  WORD_W  synchronous read data, valid 1 cycle after mem_addr is presented
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state=IDLE, cmd_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
- Reset abort: reset mid-operation aborts the command at once; mem_we drops asynchronously and no partial write completes afterwards.
- Pixel mapping: word address = BASE_ADDR + y*(H_RES/WORD_W) + x/WORD_W. Bit index = x%WORD_W; bit 0 is the leftmost pixel. The multiply is done as y*16 + y*4 (no DSP), truncated to ADDR_W.
- Command validation: checked on acceptance. The command is rejected if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES. On rejection: err pulses the next cycle, there are no memory cycles, the FSM stays IDLE and cmd_ready stays 1.
- States: IDLE, READ, WRITE, FIN.
- Row/column walk: rows are processed y0..y1; columns are word col x0/16..x1/16, left to right.
- Per-word mask: bits from max(x0, col*16)%16 to min(x1, col*16+15)%16, inclusive.
- Full-mask words (mask==16'hFFFF) with op set or clear: go directly to WRITE, writing all ones or all zeros, with no read (1 cycle per word).
- Other words: READ drives mem_addr with mem_we=0. The next cycle is WRITE, which drives the same address with mem_we=1. Write data by op:
  - set: rdata|mask
  - clear: rdata&~mask
  - invert: rdata^mask
  - Invert always uses READ.
- Address hold: mem_addr is held constant across each READ/WRITE pair.
- Transition after WRITE: to READ or WRITE for the next word, or to FIN after the last word of row y1.
- FIN: done=1 for exactly one cycle, then IDLE. cmd_ready rises in the cycle after FIN.
- Back-to-back: a new command cannot be accepted in the FIN cycle.
- Outputs: mem_addr, mem_we and mem_wdata are combinational from state and address registers. A cycle is never both a read and a write.
- Throughput: a full row costs 20 cycles when all words are full. A partial edge word costs 2 cycles.
- Degenerate rectangle: a 1x1 rectangle is legal and costs 2 cycles plus FIN.
- Memory contract: no backpressure on the memory port. The RAM must accept one access per cycle.

Decomposition:
- Shared package/header:
  - op encodings (OP_CLR, OP_SET, OP_INV)
  - H_RES, V_RES, WORD_W
  - WORDS_PER_ROW = H_RES/WORD_W
  - the FSM state encoding
- One natural sub-module, edge_mask_gen: purely combinational, (x0, x1, col) -> 16-bit mask plus is_full flag. It is unit-testable on its own.
- Address, row and column counters and the FSM stay in screen_rect_writer.

Test Plan:
- Single pixel set (3,0)-(3,0), RAM word 0 = 0x0000 -> READ addr 0, then WRITE addr 0 data 0x0008, then done pulse; 3 cycles after accept.
- Full row set x 0..319, y 5 -> 20 consecutive WRITEs, addr 100..119, data 0xFFFF, no READ cycles, then done.
- Clear x 10..20, y 1, RAM preloaded 0xFFFF -> WRITE addr 20 data 0x03FF, then WRITE addr 21 data 0xFFE0, each preceded by a READ of the same address.
- Invert (0,0)-(15,1) on RAM 0x00F0 -> addr 0 and 20 both written 0xFF0F via READ/WRITE pairs (invert never skips the read).
- Invalid x1=320, or x0=5 with x1=4 -> err pulse 1 cycle, mem_we stays 0, busy stays 0, cmd_ready stays 1.
- Reset asserted during the 3rd word of a 10-word fill -> mem_we=0 immediately; after release busy=0, cmd_ready=1, and no done pulse; a following 1-pixel command completes normally.
